// File: rtl/router_pkt_fifo_if.sv
// rtl/router_pkt_fifo_if.sv - write/read/status bundle for the packet-aware router output FIFO
//
// Purpose: groups the FIFO data path and status signals so the FIFO and its
// producer/consumer connect through one port.
// Ports (all in the bundle):
//   write_enb, lfd_state, data_in   write side (lfd_state tags data_in as a header)
//   read_enb                        read request
//   data_out, data_valid, pkt_last  registered read data and packet-end flag
//   full, empty, almost_full        occupancy flags
//   fill_level, hdr_pending         occupancy counters (0..DEPTH)
//   overflow                        one-cycle pulse on a dropped write
// Modports: master drives requests, slave is the FIFO.

interface router_pkt_fifo_if #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16
);
  localparam int AW = $clog2(DEPTH);

  logic              write_enb;
  logic              lfd_state;
  logic [DATA_W-1:0] data_in;
  logic              read_enb;
  logic [DATA_W-1:0] data_out;
  logic              data_valid;
  logic              pkt_last;
  logic              full;
  logic              empty;
  logic              almost_full;
  logic [AW:0]       fill_level;
  logic [AW:0]       hdr_pending;
  logic              overflow;

  modport master (
    output write_enb, lfd_state, data_in, read_enb,
    input  data_out, data_valid, pkt_last, full, empty, almost_full,
           fill_level, hdr_pending, overflow
  );

  modport slave (
    input  write_enb, lfd_state, data_in, read_enb,
    output data_out, data_valid, pkt_last, full, empty, almost_full,
           fill_level, hdr_pending, overflow
  );
endinterface

// File: rtl/router_pkt_fifo.sv
// rtl/router_pkt_fifo.sv - packet-aware output FIFO with length tracking and status
//
// Purpose: stores {header flag, data word} entries; on the read side the
// header length field data[DATA_W-1:2] loads a counter so the final (parity)
// word of each packet is flagged with pkt_last.
// Ports:
//   clock       rising-edge clock
//   resetn      asynchronous active-low reset
//   soft_reset  synchronous flush, wins over any traffic in the same cycle
//   fifo        router_pkt_fifo_if.slave (requests, read data, status)

module router_pkt_fifo #(
  parameter int DATA_W    = 8,
  parameter int DEPTH     = 16,
  parameter int AF_MARGIN = 2
) (
  input  logic            clock,
  input  logic            resetn,
  input  logic            soft_reset,
  router_pkt_fifo_if.slave fifo
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0]       LVL_FULL = (AW+1)'(DEPTH);
  localparam logic [AW:0]       LVL_AF   = (AW+1)'(DEPTH - AF_MARGIN);
  localparam logic [DATA_W-2:0] REM_ONE  = (DATA_W-1)'(1);

  logic [DATA_W:0]   mem [DEPTH];
  logic [AW:0]       wr_ptr, rd_ptr, level, hdr_cnt;
  logic [DATA_W-2:0] remain;
  logic [DATA_W-1:0] dout_q;
  logic              valid_q, last_q, ovf_q;

  logic              full_c, empty_c, wr_ok, rd_ok;
  logic              wr_hdr, rd_hdr;
  logic [DATA_W:0]   rd_entry;
  logic [DATA_W-3:0] rd_len;

  // Flags come only from the registered level, so outputs never see inputs combinationally.
  always_comb begin
    full_c   = (level == LVL_FULL);
    empty_c  = (level == '0);
    wr_ok    = fifo.write_enb & ~full_c;
    rd_ok    = fifo.read_enb & ~empty_c;
    wr_hdr   = wr_ok & fifo.lfd_state;
    rd_entry = mem[rd_ptr[AW-1:0]];
    rd_hdr   = rd_ok & rd_entry[DATA_W];
    rd_len   = rd_entry[DATA_W-1:2];
  end

  always_ff @(posedge clock) begin
    if (wr_ok && !soft_reset) begin
      mem[wr_ptr[AW-1:0]] <= {fifo.lfd_state, fifo.data_in};
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level   <= '0;
      hdr_cnt <= '0;
      remain  <= '0;
      dout_q  <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else if (soft_reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level   <= '0;
      hdr_cnt <= '0;
      remain  <= '0;
      dout_q  <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      ovf_q   <= fifo.write_enb & full_c;
      wr_ptr  <= wr_ptr + {{AW{1'b0}}, wr_ok};
      rd_ptr  <= rd_ptr + {{AW{1'b0}}, rd_ok};
      level   <= level + {{AW{1'b0}}, wr_ok} - {{AW{1'b0}}, rd_ok};
      // A header written and read in the same cycle leaves the count unchanged.
      hdr_cnt <= hdr_cnt + {{AW{1'b0}}, wr_hdr} - {{AW{1'b0}}, rd_hdr};
      valid_q <= rd_ok;
      last_q  <= 1'b0;
      if (rd_ok) begin
        dout_q <= rd_entry[DATA_W-1:0];
        if (rd_entry[DATA_W]) begin
          // Payload plus the trailing parity word; a header arriving early simply reloads.
          remain <= {1'b0, rd_len} + REM_ONE;
        end else if (remain != '0) begin
          remain <= remain - REM_ONE;
          last_q <= (remain == REM_ONE);
        end
      end
    end
  end

  assign fifo.data_out    = dout_q;
  assign fifo.data_valid  = valid_q;
  assign fifo.pkt_last    = last_q;
  assign fifo.full        = full_c;
  assign fifo.empty       = empty_c;
  assign fifo.almost_full = (level >= LVL_AF);
  assign fifo.fill_level  = level;
  assign fifo.hdr_pending = hdr_cnt;
  assign fifo.overflow    = ovf_q;
endmodule

// File: tb/tb_router_pkt_fifo.sv
// tb/tb_router_pkt_fifo.sv - randomized self-checking bench for router_pkt_fifo

module tb_router_pkt_fifo;
  logic clock = 1'b0;
  logic resetn = 1'b0;
  logic soft_reset = 1'b0;

  router_pkt_fifo_if #(.DATA_W(8), .DEPTH(16)) bus ();

  router_pkt_fifo #(.DATA_W(8), .DEPTH(16), .AF_MARGIN(2)) dut (
    .clock(clock), .resetn(resetn), .soft_reset(soft_reset), .fifo(bus)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int failures = 0;
  bit chk_en = 1'b0;

  // Reference: a plain queue; pkt_last is decided when the word is enqueued,
  // since the read order equals the write order.
  typedef struct { logic [7:0] d; bit hdr; bit last; } ent_t;
  ent_t q[$];
  logic [7:0] m_dout;
  bit m_valid, m_last, m_ovf;
  int m_hdr, w_remain;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic void model_reset();
    q.delete();
    m_dout = 8'h00; m_valid = 0; m_last = 0; m_ovf = 0; m_hdr = 0; w_remain = 0;
  endfunction

  function automatic void model_update();
    bit full, empty, rd, wr;
    ent_t e;
    if (soft_reset) begin
      model_reset();
      return;
    end
    full  = (q.size() == 16);
    empty = (q.size() == 0);
    rd = bus.read_enb && !empty;
    wr = bus.write_enb && !full;
    m_ovf = bus.write_enb && full;
    m_valid = rd;
    m_last = 0;
    if (rd) begin
      e = q.pop_front();
      m_dout = e.d;
      m_last = e.last;
      if (e.hdr) m_hdr--;
    end
    if (wr) begin
      e.d = bus.data_in;
      e.hdr = bus.lfd_state;
      e.last = 0;
      if (bus.lfd_state) begin
        w_remain = int'(bus.data_in[7:2]) + 1;
        m_hdr++;
      end else if (w_remain != 0) begin
        e.last = (w_remain == 1);
        w_remain--;
      end
      q.push_back(e);
    end
  endfunction

  always @(negedge clock) begin
    if (chk_en) begin
      chk("data_valid", 32'(bus.data_valid), 32'(m_valid));
      chk("data_out", 32'(bus.data_out), 32'(m_dout));
      chk("pkt_last", 32'(bus.pkt_last), 32'(m_last));
      chk("overflow", 32'(bus.overflow), 32'(m_ovf));
      chk("fill_level", 32'(bus.fill_level), 32'(q.size()));
      chk("full", 32'(bus.full), 32'(q.size() == 16));
      chk("empty", 32'(bus.empty), 32'(q.size() == 0));
      chk("almost_full", 32'(bus.almost_full), 32'(q.size() >= 14));
      chk("hdr_pending", 32'(bus.hdr_pending), 32'(m_hdr));
    end
  end

  task automatic drive(bit we, bit lfd, logic [7:0] din, bit re, bit sr);
    bus.write_enb = we; bus.lfd_state = lfd; bus.data_in = din;
    bus.read_enb = re; soft_reset = sr;
    @(posedge clock);
    model_update();
    @(negedge clock);
    bus.write_enb = 0; bus.read_enb = 0; bus.lfd_state = 0; soft_reset = 0;
  endtask

  task automatic wr(bit lfd, logic [7:0] din); drive(1, lfd, din, 0, 0); endtask
  task automatic rd(); drive(0, 0, 8'h00, 1, 0); endtask
  task automatic drain(); while (q.size() != 0) rd(); endtask

  task automatic async_reset(string tag);
    #2 resetn = 1'b0;
    #1;
    chk({tag, "_empty"}, 32'(bus.empty), 32'd1);
    chk({tag, "_full"}, 32'(bus.full), 32'd0);
    chk({tag, "_dout"}, 32'(bus.data_out), 32'd0);
    chk({tag, "_level"}, 32'(bus.fill_level), 32'd0);
    model_reset();
    @(negedge clock);
    resetn = 1'b1;
  endtask

  // Reads n words and returns a bit per read showing data_valid & pkt_last.
  task automatic read_flags(int n, output logic [7:0] flags);
    flags = '0;
    for (int i = 0; i < n; i++) begin
      rd();
      flags[i] = bus.data_valid & bus.pkt_last;
    end
  endtask

  logic [7:0] flags;

  initial begin
    bus.write_enb = 0; bus.lfd_state = 0; bus.data_in = 0; bus.read_enb = 0;
    model_reset();
    #12;
    chk("rst_empty", 32'(bus.empty), 32'd1);
    chk("rst_level", 32'(bus.fill_level), 32'd0);
    chk("rst_valid", 32'(bus.data_valid), 32'd0);
    @(negedge clock);
    resetn = 1'b1;
    chk_en = 1'b1;

    // Fill to 16, overflow on the 17th, then drain in order.
    for (int i = 0; i < 17; i++) begin
      wr(0, 8'(8'hA0 + i));
      if (i == 12) chk("af_at13", 32'(bus.almost_full), 32'd0);
      if (i == 13) chk("af_at14", 32'(bus.almost_full), 32'd1);
    end
    chk("fill_level16", 32'(bus.fill_level), 32'd16);
    chk("full16", 32'(bus.full), 32'd1);
    chk("ovf_pulse", 32'(bus.overflow), 32'd1);
    drive(0, 0, 8'h00, 0, 0);
    chk("ovf_once", 32'(bus.overflow), 32'd0);
    rd();
    chk("first_out", 32'(bus.data_out), 32'hA0);
    drain();
    chk("last_out", 32'(bus.data_out), 32'hAF);

    // Packet with len 3: pkt_last only on the 5th word.
    wr(1, 8'h0C); wr(0, 8'h11); wr(0, 8'h22); wr(0, 8'h33); wr(0, 8'h44);
    chk("hdr_pend1", 32'(bus.hdr_pending), 32'd1);
    read_flags(5, flags);
    chk("pkt3_last", 32'(flags), 32'h10);
    chk("hdr_pend0", 32'(bus.hdr_pending), 32'd0);

    // len 0: header then parity.
    wr(1, 8'h03); wr(0, 8'h5A);
    read_flags(2, flags);
    chk("len0_last", 32'(flags), 32'h02);

    // Truncated packet: second header reloads the count.
    wr(1, 8'h0C); wr(0, 8'h01); wr(1, 8'h04); wr(0, 8'h02); wr(0, 8'h03);
    read_flags(5, flags);
    chk("trunc_last", 32'(flags), 32'h10);

    // Header written and read in the same cycle.
    wr(1, 8'h08);
    drive(1, 1, 8'h00, 1, 0);
    chk("hdr_same_cyc", 32'(bus.hdr_pending), 32'd1);
    drain();

    // Concurrency at full and at empty.
    for (int i = 0; i < 16; i++) wr(0, 8'($urandom));
    drive(1, 0, 8'hEE, 1, 0);
    chk("conc_full_lvl", 32'(bus.fill_level), 32'd15);
    chk("conc_full_ovf", 32'(bus.overflow), 32'd1);
    drain();
    drive(1, 0, 8'h77, 1, 0);
    chk("conc_empty_lvl", 32'(bus.fill_level), 32'd1);
    chk("conc_empty_vld", 32'(bus.data_valid), 32'd0);
    drain();

    // Stream 40 words across pointer wrap at level 8.
    for (int i = 0; i < 8; i++) wr(0, 8'($urandom));
    for (int i = 0; i < 40; i++) drive(1, 0, 8'($urandom), 1, 0);
    chk("wrap_level", 32'(bus.fill_level), 32'd8);
    drain();

    // soft_reset with 5 words and one pending header.
    wr(1, 8'h10); for (int i = 0; i < 4; i++) wr(0, 8'($urandom));
    chk("sr_pre_hdr", 32'(bus.hdr_pending), 32'd1);
    drive(1, 1, 8'h20, 1, 1);
    chk("sr_level", 32'(bus.fill_level), 32'd0);
    chk("sr_hdr", 32'(bus.hdr_pending), 32'd0);
    chk("sr_empty", 32'(bus.empty), 32'd1);

    // Randomized traffic with phases of write/read bias.
    for (int i = 0; i < 2000; i++) begin
      int wp;
      wp = ((i / 250) % 2 == 0) ? 75 : 35;
      if (i == 700) async_reset("mid");
      drive($urandom_range(99) < wp, $urandom_range(5) == 0, 8'($urandom),
            $urandom_range(99) < 55, $urandom_range(199) == 0);
    end

    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
